w5300_common_regs_init_seq: RTL and testbench

W5300_COMMON_REGS_INIT_SEQ -- requirements
Module: w5300_common_regs_init_seq

---
 rtl/w5300_common_regs_init_seq.sv | 170 +++++++++++++++++
 tb/tb_w5300_common_regs_init_seq.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_common_regs_init_seq.sv
// W5300 common-register init sequencer: walks a register LUT over the host bus.
// Define W5300_INIT_VERIFY_EN to turn op=0 entries into read-verify accesses.
module w5300_common_regs_init_seq #(
    parameter int LUT_DEPTH = 12,
    parameter int T_SETUP   = 1,
    parameter int T_STROBE  = 4,
    parameter int T_RECOVER = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [5:0]  lut_index,
    input  logic [26:0] lut_data,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    output logic        bus_oe,
    output logic        cs_n,
    output logic        wr_n,
    output logic        rd_n,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  err_index
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_SETUP, S_STROBE, S_RECOVER, S_DONE
    } state_t;

    localparam logic [5:0] LAST_IDX    = 6'(LUT_DEPTH - 1);
    localparam logic [3:0] SETUP_END   = 4'(T_SETUP - 1);
    localparam logic [3:0] STROBE_END  = 4'(T_STROBE - 1);
    localparam logic [3:0] RECOVER_END = 4'(T_RECOVER - 1);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [26:0] entry_q, entry_d;
`ifdef W5300_INIT_VERIFY_EN
    logic        err_q, err_d;
    logic [5:0]  err_idx_q, err_idx_d;
`else
    logic        unused_din;
    assign unused_din = ^bus_din;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        entry_d   = entry_q;
`ifdef W5300_INIT_VERIFY_EN
        err_d     = err_q;
        err_idx_d = err_idx_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
`ifdef W5300_INIT_VERIFY_EN
                    err_d     = 1'b0;
                    err_idx_d = '0;
`endif
                end
            end
            S_FETCH: begin
                entry_d = lut_data;
                cnt_d   = '0;
`ifdef W5300_INIT_VERIFY_EN
                state_d = S_SETUP;
`else
                // Reads are not performed: skip straight to the next entry
                if (lut_data[26]) begin
                    state_d = S_SETUP;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = S_FETCH;
                end
`endif
            end
            S_SETUP: begin
                if (cnt_q == SETUP_END) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == STROBE_END) begin
                    cnt_d   = '0;
                    state_d = S_RECOVER;
`ifdef W5300_INIT_VERIFY_EN
                    if (!entry_q[26] && bus_din != entry_q[15:0]) begin
                        err_d = 1'b1;
                        if (!err_q) err_idx_d = idx_q;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == RECOVER_END) begin
                    cnt_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            entry_q   <= '0;
`ifdef W5300_INIT_VERIFY_EN
            err_q     <= 1'b0;
            err_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            entry_q   <= entry_d;
`ifdef W5300_INIT_VERIFY_EN
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
`endif
        end
    end

    logic access;
    logic is_wr;
    assign access = (state_q == S_SETUP) || (state_q == S_STROBE);
    assign is_wr  = entry_q[26];

    assign lut_index = idx_q;
    assign cs_n      = !access;
    assign bus_addr  = access ? entry_q[25:16] : 10'd0;
    assign bus_oe    = access && is_wr;
    assign bus_dout  = (access && is_wr) ? entry_q[15:0] : 16'd0;
    assign wr_n      = !((state_q == S_STROBE) && is_wr);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
`ifdef W5300_INIT_VERIFY_EN
    assign rd_n      = !((state_q == S_STROBE) && !is_wr);
    assign error     = err_q;
    assign err_index = err_idx_q;
`else
    assign rd_n      = 1'b1;
    assign error     = 1'b0;
    assign err_index = 6'd0;
`endif

endmodule

// File: tb/tb_w5300_common_regs_init_seq.sv
// Directed bench for w5300_common_regs_init_seq with a 3-entry LUT.
// Read-verify scenarios build only when W5300_INIT_VERIFY_EN is defined.
module tb_w5300_common_regs_init_seq;

    localparam int MAXC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  lut_index;
    logic [26:0] lut_data;
    logic [9:0]  bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din = 16'h0000;
    logic        bus_oe, cs_n, wr_n, rd_n, busy, done, error;
    logic [5:0]  err_index;

    logic [26:0] lut [0:3];

    int checks = 0;
    int errors = 0;

    logic        tr_cs [0:MAXC-1];
    logic        tr_wr [0:MAXC-1];
    logic        tr_rd [0:MAXC-1];
    logic        tr_oe [0:MAXC-1];
    logic        tr_done [0:MAXC-1];
    logic        tr_busy [0:MAXC-1];
    logic        tr_err [0:MAXC-1];
    logic [5:0]  tr_eidx [0:MAXC-1];
    logic [5:0]  tr_idx [0:MAXC-1];
    logic [9:0]  tr_addr [0:MAXC-1];
    logic [15:0] tr_dout [0:MAXC-1];
    int          done_at;

    always #5 clk = ~clk;

    assign lut_data = (lut_index < 6'd3) ? lut[lut_index[1:0]] : 27'd0;

    w5300_common_regs_init_seq #(.LUT_DEPTH(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .lut_index(lut_index), .lut_data(lut_data),
        .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_din(bus_din),
        .bus_oe(bus_oe), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
        .busy(busy), .done(done), .error(error), .err_index(err_index)
    );

    // Pulses start, then records one sample per cycle (cycle 0 = FETCH of
    // entry 0) until three cycles past done; start re-pulsed at pulse_at.
    task automatic capture(input int pulse_at);
        done_at = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < MAXC; c++) begin
            tr_cs[c] = cs_n;     tr_wr[c] = wr_n;   tr_rd[c] = rd_n;
            tr_oe[c] = bus_oe;   tr_done[c] = done; tr_busy[c] = busy;
            tr_err[c] = error;   tr_eidx[c] = err_index;
            tr_idx[c] = lut_index;
            tr_addr[c] = bus_addr; tr_dout[c] = bus_dout;
            if (done && done_at < 0) done_at = c;
            if (done_at >= 0 && c >= done_at + 3) break;
            start = (c == pulse_at);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (done_at < 0) begin
            errors++;
            $display("FAIL capture_timeout no done within %0d cycles", MAXC);
            done_at = MAXC - 4;
        end
    endtask

    task automatic count_low(input int a, input int b,
                             output int ncs, output int nwr, output int nrd);
        ncs = 0; nwr = 0; nrd = 0;
        for (int c = a; c <= b; c++) begin
            if (!tr_cs[c]) ncs++;
            if (!tr_wr[c]) nwr++;
            if (!tr_rd[c]) nrd++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, wr_n, rd_n, bus_oe, busy, done, error} !== 7'b1110000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 1110000",
                     {cs_n, wr_n, rd_n, bus_oe, busy, done, error});
        end
        checks++;
        if ({lut_index, bus_addr, bus_dout, err_index} !== 38'd0) begin
            errors++;
            $display("FAIL reset_bus got %0h/%0h/%0h/%0h want 0",
                     lut_index, bus_addr, bus_dout, err_index);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_writes;
        lut[0] = {1'b1, 10'h001, 16'h1111};
        lut[1] = {1'b1, 10'h018, 16'hA5A5};
        lut[2] = {1'b1, 10'h3FF, 16'hFFFF};
        lut[3] = 27'd0;
    endtask

    task automatic test_all_writes;
        logic [9:0]  ea [0:2];
        logic [15:0] ev [0:2];
        int ncs, nwr, nrd, bad;
        ea[0] = 10'h001; ea[1] = 10'h018; ea[2] = 10'h3FF;
        ev[0] = 16'h1111; ev[1] = 16'hA5A5; ev[2] = 16'hFFFF;
        load_writes();
        capture(-1);
        checks++;
        if (done_at !== 24) begin
            errors++;
            $display("FAIL wr_done_at got %0d want 24", done_at);
        end
        for (int k = 0; k < 3; k++) begin
            count_low(8 * k, 8 * k + 7, ncs, nwr, nrd);
            checks++;
            if (ncs !== 5 || nwr !== 4 || nrd !== 0) begin
                errors++;
                $display("FAIL wr_strobes e%0d got cs%0d wr%0d rd%0d want 5 4 0",
                         k, ncs, nwr, nrd);
            end
            checks++;
            if (tr_addr[8*k+1] !== ea[k] || tr_addr[8*k+4] !== ea[k] ||
                tr_dout[8*k+1] !== ev[k] || tr_dout[8*k+5] !== ev[k]) begin
                errors++;
                $display("FAIL wr_bus e%0d got %0h/%0h want %0h/%0h",
                         k, tr_addr[8*k+4], tr_dout[8*k+5], ea[k], ev[k]);
            end
            checks++;
            if (tr_idx[8*k] !== 6'(k) || tr_cs[8*k] !== 1'b1 ||
                tr_oe[8*k+1] !== 1'b1 || tr_wr[8*k+1] !== 1'b1 ||
                tr_wr[8*k+2] !== 1'b0 || tr_cs[8*k+6] !== 1'b1) begin
                errors++;
                $display("FAIL wr_phase e%0d idx %0d cs %b oe %b wr %b%b want %0d 1 1 10",
                         k, tr_idx[8*k], tr_cs[8*k], tr_oe[8*k+1],
                         tr_wr[8*k+1], tr_wr[8*k+2], k);
            end
        end
        bad = 0;
        for (int c = 0; c <= done_at + 3; c++)
            if ((!tr_wr[c] && tr_cs[c]) || (!tr_wr[c] && !tr_rd[c])) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL wr_strobe_rule got %0d bad cycles want 0", bad);
        end
        checks++;
        if (tr_done[done_at+1] !== 1'b0 || tr_busy[done_at+1] !== 1'b0 ||
            tr_idx[done_at+2] !== 6'd2) begin
            errors++;
            $display("FAIL wr_after_done done %b busy %b idx %0d want 0 0 2",
                     tr_done[done_at+1], tr_busy[done_at+1], tr_idx[done_at+2]);
        end
    endtask

    task automatic test_mixed;
        int ncs, nwr, nrd;
        lut[0] = {1'b1, 10'h020, 16'h0001};
        lut[1] = {1'b0, 10'h000, 16'h3800};
        lut[2] = {1'b1, 10'h1F0, 16'hBEEF};
        bus_din = 16'h3800;
        capture(-1);
`ifdef W5300_INIT_VERIFY_EN
        checks++;
        if (done_at !== 24) begin
            errors++;
            $display("FAIL mix_done_at got %0d want 24", done_at);
        end
        count_low(8, 15, ncs, nwr, nrd);
        checks++;
        if (ncs !== 5 || nwr !== 0 || nrd !== 4) begin
            errors++;
            $display("FAIL mix_read e1 got cs%0d wr%0d rd%0d want 5 0 4",
                     ncs, nwr, nrd);
        end
        checks++;
        if (tr_oe[9] !== 1'b0 || tr_oe[11] !== 1'b0 || tr_addr[10] !== 10'h000) begin
            errors++;
            $display("FAIL mix_read_bus oe %b%b addr %0h want 00 0",
                     tr_oe[9], tr_oe[11], tr_addr[10]);
        end
`else
        checks++;
        if (done_at !== 17) begin
            errors++;
            $display("FAIL mix_done_at got %0d want 17", done_at);
        end
        count_low(0, done_at + 3, ncs, nwr, nrd);
        checks++;
        if (ncs !== 10 || nwr !== 8 || nrd !== 0) begin
            errors++;
            $display("FAIL mix_strobes got cs%0d wr%0d rd%0d want 10 8 0",
                     ncs, nwr, nrd);
        end
        checks++;
        if (tr_idx[8] !== 6'd1 || tr_idx[9] !== 6'd2 || tr_addr[10] !== 10'h1F0 ||
            tr_dout[12] !== 16'hBEEF) begin
            errors++;
            $display("FAIL mix_skip idx %0d %0d bus %0h/%0h want 1 2 1f0/beef",
                     tr_idx[8], tr_idx[9], tr_addr[10], tr_dout[12]);
        end
`endif
        checks++;
        if (tr_err[done_at+1] !== 1'b0) begin
            errors++;
            $display("FAIL mix_error got %b want 0", tr_err[done_at+1]);
        end
    endtask

`ifdef W5300_INIT_VERIFY_EN
    task automatic test_mismatch;
        int ncs, nwr, nrd;
        lut[0] = {1'b1, 10'h020, 16'h0001};
        lut[1] = {1'b0, 10'h000, 16'h3800};
        lut[2] = {1'b0, 10'h010, 16'h1234};
        bus_din = 16'h0000;
        capture(-1);
        checks++;
        if (done_at !== 24) begin
            errors++;
            $display("FAIL mm_done_at got %0d want 24", done_at);
        end
        count_low(16, 23, ncs, nwr, nrd);
        checks++;
        if (nrd !== 4 || tr_addr[18] !== 10'h010) begin
            errors++;
            $display("FAIL mm_e2_read rd%0d addr %0h want 4 010", nrd, tr_addr[18]);
        end
        checks++;
        if (tr_err[done_at+1] !== 1'b1 || tr_eidx[done_at+1] !== 6'd1) begin
            errors++;
            $display("FAIL mm_err got %b idx %0d want 1 1",
                     tr_err[done_at+1], tr_eidx[done_at+1]);
        end
    endtask
`endif

    task automatic test_restart_clears;
        load_writes();
        capture(-1);
        checks++;
        if (tr_err[0] !== 1'b0 || tr_eidx[0] !== 6'd0 || tr_idx[0] !== 6'd0) begin
            errors++;
            $display("FAIL restart_clear err %b idx %0d lut %0d want 0 0 0",
                     tr_err[0], tr_eidx[0], tr_idx[0]);
        end
    endtask

    task automatic test_start_ignored;
        load_writes();
        capture(3);
        checks++;
        if (done_at !== 24 || tr_idx[8] !== 6'd1 || tr_idx[16] !== 6'd2) begin
            errors++;
            $display("FAIL busy_start done_at %0d idx %0d %0d want 24 1 2",
                     done_at, tr_idx[8], tr_idx[16]);
        end
        capture(24);
        checks++;
        if (tr_busy[done_at+1] !== 1'b0 || tr_busy[done_at+2] !== 1'b0 ||
            tr_done[done_at+1] !== 1'b0) begin
            errors++;
            $display("FAIL done_start busy %b%b done %b want 00 0",
                     tr_busy[done_at+1], tr_busy[done_at+2], tr_done[done_at+1]);
        end
    endtask

    task automatic test_reset_mid;
        int spurious;
        load_writes();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        checks++;
        if (wr_n !== 1'b0 || cs_n !== 1'b0 || lut_index !== 6'd2) begin
            errors++;
            $display("FAIL mid_pre wr %b cs %b idx %0d want 0 0 2",
                     wr_n, cs_n, lut_index);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cs_n, wr_n, rd_n, busy, done} !== 5'b11100 || lut_index !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset got %b idx %0d want 11100 0",
                     {cs_n, wr_n, rd_n, busy, done}, lut_index);
        end
        rst = 1'b1;
        spurious = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            errors++;
            $display("FAIL mid_no_done got %0d busy/done cycles want 0", spurious);
        end
        capture(-1);
        checks++;
        if (tr_idx[0] !== 6'd0 || done_at !== 24) begin
            errors++;
            $display("FAIL mid_rerun idx %0d done_at %0d want 0 24",
                     tr_idx[0], done_at);
        end
    endtask

    initial begin
        load_writes();
        test_reset();
        test_all_writes();
        test_mixed();
`ifdef W5300_INIT_VERIFY_EN
        test_mismatch();
`endif
        test_restart_clears();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
